frame_buffer_arbiter: RTL
=========================

Name: frame_buffer_arbiter

Overview:
Shares the single-port image frame buffer between one pixel writer (sensor capture path) and NUM_RD pixel readers (image send path, host/debug readback). Arbitrates whole bursts. Fixed priority for the writer, round-robin among readers. Drives the RAM port and returns read data tagged with the reader index. Sits between the capture/send engines and the frame-buffer RAM, under the top-level controller.

Parameters:
ADDR_W, `ImageAddrWidth, frame-buffer address width
DATA_W, `ImageBitDepth, pixel width
NUM_RD, 2, number of reader requesters (2..4)
MAX_BURST, 16, maximum beats per grant before forced re-arbitration (power of 2, >=2)

Ports:
clock  in  1  system clock
reset_bar  in  1  asynchronous active-low reset
wr_req  in  1  writer requests / presents a beat
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_last  in  1  final beat of writer burst
wr_ack  out  1  write beat accepted this cycle
rd_req  in  NUM_RD  per-reader request / beat present
rd_addr  in  NUM_RD*ADDR_W  per-reader address, reader i at [i*ADDR_W +: ADDR_W]
rd_last  in  NUM_RD  per-reader final beat
rd_ack  out  NUM_RD  one-hot, read beat accepted this cycle
rd_valid  out  1  read data valid
rd_id  out  $clog2(NUM_RD)  reader index owning rd_data
rd_data  out  DATA_W  read pixel
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en & ~mem_we
busy  out  1  a burst is granted

Behaviour:
- Reset (async, reset_bar=0): state IDLE. All outputs 0. Round-robin pointer = reader 0. Beat counter = 0. A pending rd_valid is dropped.
- FSM states: IDLE, GRANT_WR, GRANT_RD.
- IDLE: if wr_req, go to GRANT_WR. Else if any rd_req, go to GRANT_RD with owner = first requesting reader at or after the RR pointer (wrapping). Else stay. The grant decision takes one cycle; no beat is accepted in IDLE.
- GRANT_WR: each cycle with wr_req=1, wr_ack=1, mem_en=1, mem_we=1, and mem_addr/wdata = wr_addr/wr_data (combinational pass-through). wr_req=0 inserts a bubble; the grant is held.
- GRANT_RD: each cycle with rd_req[owner]=1, rd_ack[owner]=1, mem_en=1, mem_we=0, mem_addr = rd_addr[owner]. One cycle later: rd_valid=1, rd_id = owner, rd_data = mem_rdata.
- Burst end: on an accepted beat with last=1, or the MAX_BURSTth accepted beat. Return to IDLE, clear the counter. On a reader burst end, RR pointer = owner+1 mod NUM_RD. A reader that was cut off must re-request.
- IDLE separates bursts, so throughput is 1 idle cycle per burst and back-to-back bursts by one requester are allowed.
- Writer preempts nothing mid-burst. It wins only in IDLE.
- Simultaneous wr_req and rd_req in IDLE: writer wins.
- Requester drops req mid-burst with no last: grant is held indefinitely. The requester must deassert only after last.
- mem_en=0 whenever no beat is accepted. Outputs to the RAM are never asserted in IDLE.
- rd_valid follows an accepted read beat by exactly 1 cycle, including the beat that ends a burst.

Optional Feature:
ARB_STARVE_GUARD_EN
- With it: a 2-bit counter counts consecutive writer grants taken while any rd_req is high. When it reaches 3, the next IDLE decision goes to readers even if wr_req=1. The counter clears on any reader grant.
- Without it: strict writer priority; readers can starve.

Decomposition:
- Package fb_arb_pkg: state enum (IDLE/GRANT_WR/GRANT_RD, logic [1:0]), RD_ID_W function/localparam, burst-counter width derived from MAX_BURST.
- One sub-module: rr_pick. Combinational. Inputs: request vector and pointer. Outputs: one-hot winner and index. Reused by future arbiters.

Test Plan:
- Writer only, burst of 4 with wr_last on beat 4 → wr_ack for 4 cycles, mem_we=1 for 4 cycles, busy drops on cycle after, IDLE 1 cycle.
- wr_req and rd_req[0] both rise in the same cycle → writer granted first. Reader 0 is granted after the writer's last and the IDLE cycle; rd_valid/rd_id=0 is seen 1 cycle after each rd_ack.
- Readers 0 and 1 both request continuously with 2-beat bursts → grants alternate 0,1,0,1; rd_id matches each returned beat.
- Reader 1 burst of 20 beats, no last until beat 20, MAX_BURST=16 → 16 acks, IDLE, re-grant (reader 0 if requesting), remaining 4 beats later.
- reset_bar pulsed low mid read burst, after rd_ack → all outputs 0 immediately, no rd_valid next cycle, FSM restarts in IDLE with RR pointer 0.
- With ARB_STARVE_GUARD_EN: writer requests continuously (1-beat bursts) while rd_req[0]=1 → reader 0 granted after 3rd writer burst. Without the macro, reader 0 is never granted.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and width helpers for the frame-buffer arbiter.
// Supplies fallback pixel/address widths when the image macros are not set.
`ifndef ImageAddrWidth
`define ImageAddrWidth 16
`endif
`ifndef ImageBitDepth
`define ImageBitDepth 8
`endif

package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_WR = 2'd1,
        GRANT_RD = 2'd2
    } arb_state_e;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Beat counter only needs to reach MAX_BURST-1 before the burst is closed.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst);
    endfunction

endpackage

// File: rtl/frame_buffer_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import fb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : pick
        logic             found;
        logic [IDX_W-1:0] cand;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Burst arbiter for the single-port frame buffer: one priority writer, NUM_RD round-robin readers.
// Optional ARB_STARVE_GUARD_EN: after 3 writer grants under reader pressure, readers win once.
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W    = `ImageAddrWidth,
    parameter int DATA_W    = `ImageBitDepth,
    parameter int NUM_RD    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                          clock,
    input  logic                          reset_bar,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_last,
    output logic                          wr_ack,
    input  logic [NUM_RD-1:0]             rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
    input  logic [NUM_RD-1:0]             rd_last,
    output logic [NUM_RD-1:0]             rd_ack,
    output logic                          rd_valid,
    output logic [idx_width(NUM_RD)-1:0]  rd_id,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
);

    localparam int RD_ID_W = idx_width(NUM_RD);
    localparam int CNT_W   = cnt_width(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [RD_ID_W-1:0] owner_q, owner_d;
    logic [RD_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [RD_ID_W-1:0] rd_id_q, rd_id_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               rd_valid_q, rd_valid_d;

    logic [NUM_RD-1:0]  pick_gnt;
    logic [RD_ID_W-1:0] pick_idx;
    logic               rd_any;
    logic               wr_blocked;
    logic               take_wr;
    logic               wr_beat;
    logic               rd_beat;
    logic               beat;
    logic               cur_last;
    logic               burst_end;

    rr_pick #(
        .N     (NUM_RD),
        .IDX_W (RD_ID_W)
    ) u_rr_pick (
        .req (rd_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign rd_any    = |pick_gnt;
    assign wr_beat   = (state_q == GRANT_WR) && wr_req;
    assign rd_beat   = (state_q == GRANT_RD) && rd_req[owner_q];
    assign beat      = wr_beat || rd_beat;
    assign cur_last  = (state_q == GRANT_WR) ? wr_last : rd_last[owner_q];
    assign burst_end = beat && (cur_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

`ifdef ARB_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;
    assign wr_blocked = (starve_q == 2'd3) && rd_any;
`else
    assign wr_blocked = 1'b0;
`endif

    assign take_wr = wr_req && !wr_blocked;

    // State register plus burst bookkeeping flops.
    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            rd_id_q    <= '0;
            beat_cnt_q <= '0;
            rd_valid_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_id_q    <= rd_id_d;
            beat_cnt_q <= beat_cnt_d;
            rd_valid_q <= rd_valid_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take_wr)     state_d = GRANT_WR;
                else if (rd_any) state_d = GRANT_RD;
            end
            GRANT_WR, GRANT_RD: begin
                if (burst_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rd_valid_d = rd_beat;
        rd_id_d    = rd_beat ? owner_q : '0;
        if ((state_q == IDLE) && !take_wr && rd_any) owner_d = pick_idx;
        if (burst_end) begin
            beat_cnt_d = '0;
            if (state_q == GRANT_RD)
                rr_ptr_d = (owner_q == RD_ID_W'(NUM_RD - 1)) ? '0 : owner_q + 1'b1;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Saturating count of writer grants taken while a reader was waiting.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (take_wr)     starve_d = !rd_any ? 2'd0 : (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;
            else if (rd_any) starve_d = 2'd0;
        end
    end
`endif

    always_comb begin
        wr_ack    = wr_beat;
        rd_ack    = '0;
        if (rd_beat) rd_ack[owner_q] = 1'b1;
        mem_en    = beat;
        mem_we    = wr_beat;
        mem_addr  = wr_beat ? wr_addr : rd_beat ? rd_addr[owner_q*ADDR_W +: ADDR_W] : '0;
        mem_wdata = wr_beat ? wr_data : '0;
        busy      = (state_q != IDLE);
        rd_valid  = rd_valid_q;
        rd_id     = rd_id_q;
        rd_data   = rd_valid_q ? mem_rdata : '0;
    end

endmodule
